// File: rtl/l1a_multi_chk.sv
`default_nettype none
// -----------------------------------------------------------------------------
// l1a_multi_chk: per-event L1A scan, stale-event flush and grant over NCH FIFOs.
// Optional statistics counters enabled by macro L1A_CHK_STATS_EN.  Rev 1.0
// -----------------------------------------------------------------------------
module l1a_multi_chk #(
   parameter int NCH     = 7,
   parameter int L1A_W   = 12,
   parameter int TMO_CYC = 1023
) (
   input  logic                                        CLK,
   input  logic                                        RST,
   input  logic                                        EVT_STRT,
   input  logic [L1A_W-1:0]                            EXP_L1A,
   input  logic [NCH-1:0]                              ACT_MASK,
   input  logic [NCH-1:0]                              FIFO_MT,
   input  logic [NCH-1:0]                              FIFO_HDR,
   input  logic [NCH*L1A_W-1:0]                        FIFO_L1A,
   input  logic                                        XFER_DONE,
   output logic [NCH-1:0]                              RD_EN,
   output logic                                        XFER_GO,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]    XFER_CH,
   output logic                                        BUSY,
   output logic                                        EVT_DONE,
   output logic [NCH-1:0]                              MISS_MASK,
   output logic [NCH-1:0]                              TMO_MASK,
   output logic [15:0]                                 FLUSH_WORDS,
   output logic [15:0]                                 MISS_EVTS
);

   localparam int XW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = $clog2(NCH + 1);
   localparam int TW = $clog2(TMO_CYC + 1);

   typedef enum logic [2:0] {IDLE, SCAN, WAIT, CHK, FLUSH, XFER, HOLD, DONE} state_t;

   state_t             state, state_n;
   logic [CW-1:0]      ch, ch_n, ch_inc;
   logic [TW-1:0]      timer, timer_n;
   logic [L1A_W-1:0]   exp_l1a;
   logic [NCH-1:0]     act_mask;
   logic [NCH-1:0]     miss_n, tmo_n;
   logic               first_flush, first_n;
   logic               pop;

   logic               cur_act, cur_mt, cur_hdr;
   logic [L1A_W-1:0]   cur_l1a, diff;
   logic [NCH-1:0]     cur_bit;
   logic               is_eq, is_old;

   // Explicit compare mux: ch may equal NCH and must never alias a channel.
   always_comb begin
      cur_act = 1'b0;
      cur_mt  = 1'b1;
      cur_hdr = 1'b0;
      cur_l1a = '0;
      cur_bit = '0;
      for (int i = 0; i < NCH; i++) begin
         if (ch == CW'(i)) begin
            cur_act    = act_mask[i];
            cur_mt     = FIFO_MT[i];
            cur_hdr    = FIFO_HDR[i];
            cur_l1a    = FIFO_L1A[i*L1A_W +: L1A_W];
            cur_bit[i] = 1'b1;
         end
      end
   end

   assign diff   = cur_l1a - exp_l1a;
   assign is_eq  = (diff == '0);
   assign is_old = diff[L1A_W-1];
   assign ch_inc = (ch == CW'(NCH)) ? ch : ch + CW'(1);

   always_comb begin
      state_n = state;
      ch_n    = ch;
      timer_n = timer;
      miss_n  = MISS_MASK;
      tmo_n   = TMO_MASK;
      first_n = 1'b0;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (EVT_STRT) begin
               state_n = SCAN;
               ch_n    = '0;
               miss_n  = '0;
               tmo_n   = '0;
            end
         end
         SCAN: begin
            if (ch == CW'(NCH)) begin
               state_n = DONE;
            end else if (!cur_act) begin
               ch_n = ch_inc;
            end else begin
               timer_n = '0;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (cur_mt) begin
               timer_n = timer + TW'(1);
               if (timer_n == TW'(TMO_CYC)) begin
                  miss_n  = MISS_MASK | cur_bit;
                  tmo_n   = TMO_MASK | cur_bit;
                  ch_n    = ch_inc;
                  state_n = SCAN;
               end
            end else if (!cur_hdr) begin
               state_n = FLUSH;
               first_n = 1'b1;
            end else begin
               state_n = CHK;
            end
         end
         CHK: begin
            if (is_eq) begin
               state_n = XFER;
            end else if (is_old) begin
               state_n = FLUSH;
               first_n = 1'b1;
            end else begin
               miss_n  = MISS_MASK | cur_bit;
               ch_n    = ch_inc;
               state_n = SCAN;
            end
         end
         FLUSH: begin
            // First cycle pops the word that caused entry; afterwards status reflects the new head.
            if (first_flush) begin
               pop = 1'b1;
            end else if (cur_mt) begin
               timer_n = '0;
               state_n = WAIT;
            end else if (cur_hdr) begin
               state_n = CHK;
            end else begin
               pop = 1'b1;
            end
         end
         XFER:    state_n = HOLD;
         HOLD: begin
            if (XFER_DONE) begin
               ch_n    = ch_inc;
               state_n = SCAN;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign RD_EN = pop ? cur_bit : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         ch          <= '0;
         timer       <= '0;
         first_flush <= 1'b0;
         exp_l1a     <= '0;
         act_mask    <= '0;
         MISS_MASK   <= '0;
         TMO_MASK    <= '0;
         XFER_GO     <= 1'b0;
         XFER_CH     <= '0;
         BUSY        <= 1'b0;
         EVT_DONE    <= 1'b0;
      end else begin
         state       <= state_n;
         ch          <= ch_n;
         timer       <= timer_n;
         first_flush <= first_n;
         MISS_MASK   <= miss_n;
         TMO_MASK    <= tmo_n;
         if (state == IDLE && EVT_STRT) begin
            exp_l1a  <= EXP_L1A;
            act_mask <= ACT_MASK;
         end
         XFER_GO <= (state == XFER);
         if (state == XFER) begin
            XFER_CH <= ch[XW-1:0];
         end
         BUSY     <= (state_n != IDLE);
         EVT_DONE <= (state == DONE);
      end
   end

`ifdef L1A_CHK_STATS_EN
   logic [15:0] flush_cnt, mevt_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         flush_cnt <= '0;
         mevt_cnt  <= '0;
      end else begin
         if (pop && flush_cnt != 16'hFFFF) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
         if (state == DONE && MISS_MASK != '0 && mevt_cnt != 16'hFFFF) begin
            mevt_cnt <= mevt_cnt + 16'd1;
         end
      end
   end

   assign FLUSH_WORDS = flush_cnt;
   assign MISS_EVTS   = mevt_cnt;
`else
   assign FLUSH_WORDS = '0;
   assign MISS_EVTS   = '0;
`endif

endmodule
`default_nettype wire
